// File: rtl/srv_icache_pkg.sv
// Shared constants, FSM state type and address helpers for the direct-mapped
// instruction cache.
package srv_icache_pkg;

    localparam int ADDR_W   = 32;
    localparam int WORD_W   = 32;
    localparam int LINE_W   = 128;
    localparam int WORDS    = 4;
    localparam int OFFS_W   = 2;

    // Byte address bit where the line address starts (word offset + byte lane).
    localparam int LINE_LSB = OFFS_W + 2;

    // Width of a line address (byte address with offset and byte lane dropped).
    localparam int LADDR_W  = ADDR_W - LINE_LSB;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    // Word address of the first word in a line, as presented to the refill port.
    function automatic logic [ADDR_W-1:0] line_word_addr(input logic [LADDR_W-1:0] line);
        return {2'b00, line, 2'b00};
    endfunction

endpackage

// File: rtl/srv_icache_array.sv
// Flopped tag/data/valid storage for the direct-mapped instruction cache.
// One asynchronous read port, one write port, and a clear-all for the valid bits.
// Only the valid bits are reset; tag and data contents are don't-care until written.
module srv_icache_array
    import srv_icache_pkg::*;
#(
    parameter int LINES = 16,
    parameter int IDX_W = 4,
    parameter int TAG_W = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic              rd_valid_o,
    output logic [TAG_W-1:0]  rd_tag_o,
    output logic [LINE_W-1:0] rd_data_o,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [TAG_W-1:0]  wr_tag_i,
    input  logic [LINE_W-1:0] wr_data_i,
    input  logic              clr_i
);

    logic [LINE_W-1:0] data_q [LINES];
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [LINES-1:0]  valid_q;

    // Valid bits: clear-all wins over a same-cycle write so a pending flush
    // also drops the line being filled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (clr_i) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    // Tag and data payload, written on every fill; no reset needed.
    always_ff @(posedge clk) begin
        if (we_i) begin
            data_q[wr_idx_i] <= wr_data_i;
            tag_q[wr_idx_i]  <= wr_tag_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/srv_icache.sv
// Blocking, direct-mapped instruction cache with a single outstanding refill.
// Hits are answered combinationally in IDLE; a miss latches the line address,
// issues one refill request and waits for the whole line to come back.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | serve hits combinationally; a miss latches the line, goes REQ
//   REQ   | one-cycle refill request on ext_req_o with the latched address
//   WAIT  | wait for ext_rsp_i, then write the line and return to IDLE
module srv_icache
    import srv_icache_pkg::*;
#(
    parameter int LINES    = 16,
    parameter int FLUSH_EN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              imem_req_i,
    input  logic [ADDR_W-1:0] imem_addr_i,
    output logic [WORD_W-1:0] imem_data_o,
    output logic              imem_vld_o,
    input  logic              flush_i,
    output logic              ext_req_o,
    output logic [ADDR_W-1:0] ext_addr_o,
    input  logic              ext_rsp_i,
    input  logic [LINE_W-1:0] ext_data_i,
    output logic [15:0]       miss_cnt_o
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W - LINE_LSB;

    state_e               state_q, state_d;
    logic [LADDR_W-1:0]   line_q, line_d;
    logic [15:0]          miss_cnt_q, miss_cnt_d;
    logic                 flush_pend_q, flush_pend_d;

    logic [OFFS_W-1:0]    cpu_offs;
    logic [IDX_W-1:0]     cpu_idx;
    logic [TAG_W-1:0]     cpu_tag;
    logic                 flush_eff;
    logic                 hit;

    logic                 rd_valid;
    logic [TAG_W-1:0]     rd_tag;
    logic [LINE_W-1:0]    rd_data;
    logic                 arr_we;
    logic                 arr_clr;
    logic [IDX_W-1:0]     wr_idx;
    logic [TAG_W-1:0]     wr_tag;
    logic                 vld;

    // Byte-lane bits never select anything in a word-granular fetch.
    logic [1:0]           unused_addr_lsb;
    assign unused_addr_lsb = imem_addr_i[1:0];

    assign cpu_offs  = imem_addr_i[LINE_LSB-1:2];
    assign cpu_idx   = imem_addr_i[IDX_W+LINE_LSB-1:LINE_LSB];
    assign cpu_tag   = imem_addr_i[ADDR_W-1:IDX_W+LINE_LSB];
    assign flush_eff = (FLUSH_EN != 0) && flush_i;

    // The fill target comes from the latched line, never from the live CPU
    // address, so the CPU may wander while the refill is outstanding.
    assign wr_idx = line_q[IDX_W-1:0];
    assign wr_tag = line_q[LADDR_W-1:IDX_W];

    srv_icache_array #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_array (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_idx_i   (cpu_idx),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (rd_data),
        .we_i       (arr_we),
        .wr_idx_i   (wr_idx),
        .wr_tag_i   (wr_tag),
        .wr_data_i  (ext_data_i),
        .clr_i      (arr_clr)
    );

    assign hit = imem_req_i && rd_valid && (rd_tag == cpu_tag);

    // State, latched line address, miss counter and deferred-flush flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            line_q       <= '0;
            miss_cnt_q   <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            line_q       <= line_d;
            miss_cnt_q   <= miss_cnt_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    // Next-state and array control; a flush seen mid-refill is deferred until
    // the fill lands so the returning line is discarded along with the rest.
    always_comb begin
        state_d      = state_q;
        line_d       = line_q;
        miss_cnt_d   = miss_cnt_q;
        flush_pend_d = flush_pend_q;
        vld          = 1'b0;
        arr_we       = 1'b0;
        arr_clr      = 1'b0;

        case (state_q)
            IDLE: begin
                if (flush_eff) begin
                    arr_clr = 1'b1;
                end else if (imem_req_i) begin
                    if (hit) begin
                        vld = 1'b1;
                    end else begin
                        line_d     = imem_addr_i[ADDR_W-1:LINE_LSB];
                        miss_cnt_d = miss_cnt_q + 16'd1;
                        state_d    = REQ;
                    end
                end
            end
            REQ: begin
                if (flush_eff) begin
                    flush_pend_d = 1'b1;
                end
                state_d = WAIT;
            end
            WAIT: begin
                if (flush_eff) begin
                    flush_pend_d = 1'b1;
                end
                if (ext_rsp_i) begin
                    arr_we       = 1'b1;
                    arr_clr      = flush_pend_q || flush_eff;
                    flush_pend_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign imem_vld_o  = vld;
    assign imem_data_o = rd_data[{cpu_offs, 5'd0} +: WORD_W];
    assign ext_req_o   = (state_q == REQ);
    assign ext_addr_o  = line_word_addr(line_q);
    assign miss_cnt_o  = miss_cnt_q;

endmodule

// File: tb/tb_srv_icache.sv
// Directed bench for srv_icache: a 10-cycle refill responder, a scoreboard
// queue of expected hit data, and a monitor that pops on every imem_vld_o.
module tb_srv_icache;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         imem_req_i = 1'b0;
    logic [31:0]  imem_addr_i = '0;
    logic [31:0]  imem_data_o;
    logic         imem_vld_o;
    logic         flush_i = 1'b0;
    logic         ext_req_o;
    logic [31:0]  ext_addr_o;
    logic         ext_rsp_i = 1'b0;
    logic [127:0] ext_data_i = '0;
    logic [15:0]  miss_cnt_o;

    srv_icache #(
        .LINES    (16),
        .FLUSH_EN (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req_i  (imem_req_i),
        .imem_addr_i (imem_addr_i),
        .imem_data_o (imem_data_o),
        .imem_vld_o  (imem_vld_o),
        .flush_i     (flush_i),
        .ext_req_o   (ext_req_o),
        .ext_addr_o  (ext_addr_o),
        .ext_rsp_i   (ext_rsp_i),
        .ext_data_i  (ext_data_i),
        .miss_cnt_o  (miss_cnt_o)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] exp_q [$];

    int          n_req = 0;
    int          last_req_cyc = 0;
    logic [31:0] last_req_addr = '0;
    int          mem_due = 0;
    bit          mem_pend = 1'b0;
    logic        prev_req = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Memory contents: each word holds 0xC0DE_0000 | its own byte address.
    function automatic logic [127:0] line_of(input logic [31:0] waddr);
        logic [127:0] r;
        logic [31:0]  base;
        base = {waddr[29:0], 2'b00};
        for (int k = 0; k < 4; k++) begin
            r[k*32 +: 32] = 32'hC0DE_0000 | (base + 32'(k * 4));
        end
        return r;
    endfunction

    // Refill request observer: records each request, arms the responder.
    initial forever begin
        @(negedge clk);
        if (ext_req_o) begin
            chk("ext_req_single_pulse", 32'(prev_req), 32'd0);
            n_req++;
            last_req_cyc  = cyc;
            last_req_addr = ext_addr_o;
            mem_pend      = 1'b1;
            mem_due       = cyc + 10;
        end
        prev_req = ext_req_o;
    end

    // Responder: answers 10 cycles after the request, even across a DUT reset.
    initial forever begin
        @(posedge clk);
        #1;
        if (mem_pend && cyc == mem_due) begin
            ext_rsp_i  = 1'b1;
            ext_data_i = line_of(last_req_addr);
            mem_pend   = 1'b0;
        end else begin
            ext_rsp_i  = 1'b0;
        end
    end

    // Scoreboard monitor: every hit must match the oldest expected word.
    initial forever begin
        @(negedge clk);
        if (imem_vld_o) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_hit: got data 0x%08h addr 0x%08h, none expected", imem_data_o, imem_addr_i);
            end else begin
                chk("hit_data", imem_data_o, exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Wait for imem_vld_o; lat is cycles since start, -1 on timeout.
    task automatic wait_hit(input logic [31:0] a, input int start, input int budget, output int lat);
        lat = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (imem_vld_o) begin
                lat = cyc - start;
                break;
            end
        end
        if (lat < 0) begin
            n_chk++;
            n_err++;
            $display("FAIL fetch_timeout: addr 0x%08h no hit within %0d cycles", a, budget);
            void'(exp_q.pop_back());
        end
        @(posedge clk);
        #1;
        imem_req_i = 1'b0;
    endtask

    // Called at posedge+1; returns at posedge+1 with the request dropped.
    task automatic fetch(input logic [31:0] a, input logic [31:0] exp, input int budget,
                         output int lat, output int start);
        exp_q.push_back(exp);
        imem_addr_i = a;
        imem_req_i  = 1'b1;
        start       = cyc;
        wait_hit(a, start, budget, lat);
    endtask

    int lat;
    int st;
    int nr0;
    int hits;

    initial begin
        // Reset with a request already presented.
        rst_n       = 1'b0;
        imem_req_i  = 1'b1;
        imem_addr_i = 32'h10;
        repeat (3) @(negedge clk);
        chk("rst_vld", 32'(imem_vld_o), 32'd0);
        chk("rst_ext_req", 32'(ext_req_o), 32'd0);
        chk("rst_ext_addr", ext_addr_o, 32'h0);
        chk("rst_miss_cnt", 32'(miss_cnt_o), 32'd0);
        @(posedge clk);
        #1;
        imem_req_i = 1'b0;
        rst_n      = 1'b1;
        @(posedge clk);
        #1;

        // Cold fetch of 0x14-in-line-0x10: request at +1, hit at +12.
        nr0 = n_req;
        fetch(32'h14, 32'hC0DE_0014, 40, lat, st);
        chk("cold_latency", 32'(lat), 32'd12);
        chk("cold_req_cycle", 32'(last_req_cyc - st), 32'd1);
        chk("cold_req_count", 32'(n_req - nr0), 32'd1);
        chk("cold_ext_addr", last_req_addr, 32'h4);
        chk("cold_miss_cnt", 32'(miss_cnt_o), 32'd1);

        // Four back-to-back hits across the filled line.
        exp_q.push_back(32'hC0DE_0010);
        exp_q.push_back(32'hC0DE_0014);
        exp_q.push_back(32'hC0DE_0018);
        exp_q.push_back(32'hC0DE_001C);
        hits = 0;
        for (int i = 0; i < 4; i++) begin
            imem_addr_i = 32'h10 + 32'(i * 4);
            imem_req_i  = 1'b1;
            @(negedge clk);
            if (imem_vld_o) hits++;
            @(posedge clk);
            #1;
        end
        imem_req_i = 1'b0;
        if (hits != 4) exp_q.delete();
        chk("burst_hits", 32'(hits), 32'd4);
        chk("burst_miss_cnt", 32'(miss_cnt_o), 32'd1);
        chk("burst_req_count", 32'(n_req - nr0), 32'd1);

        // Same index, different tag, then back: three refills total.
        fetch(32'h110, 32'hC0DE_0110, 40, lat, st);
        chk("conflict_latency", 32'(lat), 32'd12);
        chk("conflict_ext_addr", last_req_addr, 32'h44);
        fetch(32'h10, 32'hC0DE_0010, 40, lat, st);
        chk("refetch_latency", 32'(lat), 32'd12);
        chk("conflict_miss_cnt", 32'(miss_cnt_o), 32'd3);

        // Flush during WAIT: fill completes, then the held request misses again.
        nr0 = n_req;
        fork
            fetch(32'h20, 32'hC0DE_0020, 60, lat, st);
            begin
                repeat (5) @(posedge clk);
                #1;
                flush_i = 1'b1;
                @(posedge clk);
                #1;
                flush_i = 1'b0;
            end
        join
        chk("wait_flush_latency", 32'(lat), 32'd24);
        chk("wait_flush_req_count", 32'(n_req - nr0), 32'd2);
        chk("wait_flush_miss_cnt", 32'(miss_cnt_o), 32'd5);
        fetch(32'h10, 32'hC0DE_0010, 40, lat, st);
        chk("flushed_line_misses", 32'(lat), 32'd12);

        // Flush beats a hit in IDLE: no data, no miss, line gone afterwards.
        imem_addr_i = 32'h10;
        imem_req_i  = 1'b1;
        flush_i     = 1'b1;
        nr0         = n_req;
        @(negedge clk);
        chk("idle_flush_vld", 32'(imem_vld_o), 32'd0);
        @(posedge clk);
        #1;
        flush_i    = 1'b0;
        imem_req_i = 1'b0;
        @(negedge clk);
        chk("idle_flush_miss_cnt", 32'(miss_cnt_o), 32'd6);
        chk("idle_flush_no_req", 32'(n_req - nr0), 32'd0);
        @(posedge clk);
        #1;
        fetch(32'h10, 32'hC0DE_0010, 40, lat, st);
        chk("after_idle_flush_latency", 32'(lat), 32'd12);

        // Address moves to 0x200 during WAIT: 0x30 still filled, 0x200 misses next.
        nr0 = n_req;
        exp_q.push_back(32'hC0DE_0200);
        imem_addr_i = 32'h30;
        imem_req_i  = 1'b1;
        st          = cyc;
        repeat (4) @(posedge clk);
        #1;
        imem_addr_i = 32'h200;
        wait_hit(32'h200, st, 60, lat);
        chk("addr_change_latency", 32'(lat), 32'd24);
        chk("addr_change_ext_addr", last_req_addr, 32'h80);
        chk("addr_change_req_count", 32'(n_req - nr0), 32'd2);
        fetch(32'h30, 32'hC0DE_0030, 4, lat, st);
        chk("latched_fill_hit", 32'(lat), 32'd0);
        chk("addr_change_miss_cnt", 32'(miss_cnt_o), 32'd9);

        // Reset mid-WAIT, then the responder's stray reply lands in IDLE.
        imem_addr_i = 32'h40;
        imem_req_i  = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst_n      = 1'b0;
        imem_req_i = 1'b0;
        @(negedge clk);
        chk("midwait_rst_ext_req", 32'(ext_req_o), 32'd0);
        chk("midwait_rst_ext_addr", ext_addr_o, 32'h0);
        chk("midwait_rst_miss_cnt", 32'(miss_cnt_o), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        nr0   = n_req;
        repeat (8) @(posedge clk);
        #1;
        chk("stray_rsp_seen", 32'(mem_pend), 32'd0);
        chk("stray_no_req", 32'(n_req - nr0), 32'd0);
        fetch(32'h30, 32'hC0DE_0030, 40, lat, st);
        chk("post_rst_cold_30", 32'(lat), 32'd12);
        fetch(32'h40, 32'hC0DE_0040, 40, lat, st);
        chk("post_rst_cold_40", 32'(lat), 32'd12);
        chk("post_rst_ext_addr", last_req_addr, 32'h10);
        chk("post_rst_req_count", 32'(n_req - nr0), 32'd2);
        chk("post_rst_miss_cnt", 32'(miss_cnt_o), 32'd2);

        repeat (2) @(posedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
